pipe_ctrl_stage: RTL and testbench

//  Parametrised pipeline boundary register for the RISC-V pipeline: carries a control

---
 rtl/pipe_pkg.sv | 39 +++
 rtl/pipe_ctrl_stage_if.sv | 36 +++
 rtl/pipe_stage_reg.sv | 38 +++
 rtl/pipe_ctrl_stage.sv | 86 ++++++++
 tb/tb_pipe_ctrl_stage.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline boundary registers: the control
// bundle layout, its no-op encoding and the bit positions of each field.
package pipe_pkg;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
    } ctrl_t;

    localparam int CTRL_BITS = $bits(ctrl_t);

    // All-zero control has no architectural side effect, so it doubles as
    // the encoding of a bubble or a killed instruction.
    localparam ctrl_t CTRL_NOP = '0;

    localparam int REG_WRITE_BIT  = 3;
    localparam int RESULT_SRC_MSB = 2;
    localparam int RESULT_SRC_LSB = 1;
    localparam int MEM_WRITE_BIT  = 0;

    // Legal chain depths for a boundary register.
    function automatic logic stages_ok(input int stages);
        return (stages >= 1) && (stages <= 4);
    endfunction

    // Builds a raw control vector from its fields using the index positions.
    function automatic logic [CTRL_BITS-1:0] ctrl_pack(input logic reg_write,
                                                      input logic [1:0] result_src,
                                                      input logic mem_write);
        logic [CTRL_BITS-1:0] v;
        v = '0;
        v[REG_WRITE_BIT]                   = reg_write;
        v[RESULT_SRC_MSB:RESULT_SRC_LSB]   = result_src;
        v[MEM_WRITE_BIT]                   = mem_write;
        return v;
    endfunction

endpackage

// File: rtl/pipe_ctrl_stage_if.sv
// Bundle of hazard-control inputs, the incoming instruction bundle and the
// outgoing boundary state. The hazard unit/previous stage side is master,
// the boundary register is slave.
interface pipe_ctrl_stage_if
    import pipe_pkg::*;
#(
    parameter int CTRL_W = CTRL_BITS,
    parameter int DATA_W = 32,
    parameter int STAGES = 1,
    parameter int CNT_W  = 16
) ();

    logic              stall_i;
    logic              flush_i;
    logic              bubble_i;
    logic              valid_i;
    logic [CTRL_W-1:0] ctrl_i;
    logic [DATA_W-1:0] data_i;

    logic              valid_o;
    logic [CTRL_W-1:0] ctrl_o;
    logic [DATA_W-1:0] data_o;
    logic [STAGES-1:0] stage_vld_o;
    logic [CNT_W-1:0]  bubble_cnt_o;

    modport master (
        output stall_i, flush_i, bubble_i, valid_i, ctrl_i, data_i,
        input  valid_o, ctrl_o, data_o, stage_vld_o, bubble_cnt_o
    );

    modport slave (
        input  stall_i, flush_i, bubble_i, valid_i, ctrl_i, data_i,
        output valid_o, ctrl_o, data_o, stage_vld_o, bubble_cnt_o
    );

endinterface

// File: rtl/pipe_stage_reg.sv
// One boundary stage: valid, control and data flops. Clear kills the
// instruction (valid and control to zero, data kept), hold freezes the
// stage, otherwise the stage loads the upstream bundle.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = CTRL_BITS,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic              clear,
    input  logic              load_valid,
    input  logic [CTRL_W-1:0] load_ctrl,
    input  logic [DATA_W-1:0] load_data,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    // Clear beats hold so a flush always kills a stalled stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            ctrl  <= CTRL_W'(CTRL_NOP);
            data  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
            ctrl  <= CTRL_W'(CTRL_NOP);
        end else if (!hold) begin
            valid <= load_valid;
            ctrl  <= load_ctrl;
            data  <= load_data;
        end
    end

endmodule

// File: rtl/pipe_ctrl_stage.sv
// Pipeline boundary register chain with stall, flush and bubble insertion,
// plus a saturating count of accepted bubbles. Latency equals STAGES and
// every output is taken directly from a flop.
module pipe_ctrl_stage
    import pipe_pkg::*;
#(
    parameter int CTRL_W = CTRL_BITS,
    parameter int DATA_W = 32,
    parameter int STAGES = 1,
    parameter int CNT_W  = 16
) (
    input logic              clk,
    input logic              rst,
    pipe_ctrl_stage_if.slave bus
);

    if (!stages_ok(STAGES)) begin : g_bad_stages
        $error("pipe_ctrl_stage: STAGES must be in 1..4");
    end

    logic [STAGES-1:0] stage_valid;
    logic [CTRL_W-1:0] stage_ctrl [STAGES];
    logic [DATA_W-1:0] stage_data [STAGES];
    logic [CTRL_W-1:0] entry_ctrl;
    logic              bubble_take;
    logic [CNT_W-1:0]  bubble_cnt;

    // A bubble only takes effect when neither flush nor stall is active.
    assign bubble_take = bus.bubble_i & ~bus.flush_i & ~bus.stall_i;

    // Non-instructions enter with no-op control so ctrl_o is zero whenever
    // valid_o is low.
    assign entry_ctrl = bus.valid_i ? bus.ctrl_i : CTRL_W'(CTRL_NOP);

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            pipe_stage_reg #(
                .CTRL_W (CTRL_W),
                .DATA_W (DATA_W)
            ) u_reg (
                .clk        (clk),
                .rst        (rst),
                .hold       (bus.stall_i),
                .clear      (bus.flush_i | bubble_take),
                .load_valid (bus.valid_i),
                .load_ctrl  (entry_ctrl),
                .load_data  (bus.data_i),
                .valid      (stage_valid[k]),
                .ctrl       (stage_ctrl[k]),
                .data       (stage_data[k])
            );
        end else begin : g_next
            pipe_stage_reg #(
                .CTRL_W (CTRL_W),
                .DATA_W (DATA_W)
            ) u_reg (
                .clk        (clk),
                .rst        (rst),
                .hold       (bus.stall_i),
                .clear      (bus.flush_i),
                .load_valid (stage_valid[k-1]),
                .load_ctrl  (stage_ctrl[k-1]),
                .load_data  (stage_data[k-1]),
                .valid      (stage_valid[k]),
                .ctrl       (stage_ctrl[k]),
                .data       (stage_data[k])
            );
        end
    end

    // Count accepted bubbles, sticking at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt <= '0;
        end else if (bubble_take && (bubble_cnt != {CNT_W{1'b1}})) begin
            bubble_cnt <= bubble_cnt + 1'b1;
        end
    end

    assign bus.valid_o      = stage_valid[STAGES-1];
    assign bus.ctrl_o       = stage_ctrl[STAGES-1];
    assign bus.data_o       = stage_data[STAGES-1];
    assign bus.stage_vld_o  = stage_valid;
    assign bus.bubble_cnt_o = bubble_cnt;

endmodule

// File: tb/tb_pipe_ctrl_stage.sv
// Directed bench for pipe_ctrl_stage: a 3-deep chain for streaming, stall
// and flush, and a 2-deep chain with a 4-bit counter for bubbles and
// counter saturation. Expected values are hand-computed vector tables.
module tb_pipe_ctrl_stage;
    import pipe_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pipe_ctrl_stage_if #(.CTRL_W(4), .DATA_W(32), .STAGES(3), .CNT_W(16)) bus3 ();
    pipe_ctrl_stage_if #(.CTRL_W(4), .DATA_W(32), .STAGES(2), .CNT_W(4))  bus2 ();

    pipe_ctrl_stage #(.CTRL_W(4), .DATA_W(32), .STAGES(3), .CNT_W(16)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    pipe_ctrl_stage #(.CTRL_W(4), .DATA_W(32), .STAGES(2), .CNT_W(4)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    typedef struct packed {
        logic        stall;
        logic        flush;
        logic        bubble;
        logic        valid;
        logic [3:0]  ctrl;
        logic [31:0] data;
        logic        exp_valid;
        logic [3:0]  exp_ctrl;
        logic [31:0] exp_data;
        logic [2:0]  exp_svld;
        logic [15:0] exp_cnt;
    } vec_t;

    int   check_count = 0;
    int   error_count = 0;
    vec_t tab3 [17];
    vec_t tab2 [6];

    function automatic vec_t mk(input int s, input int f, input int b, input int v,
                                input int c, input int d, input int ev, input int ec,
                                input int ed, input int es, input int en);
        vec_t r;
        r.stall     = 1'(s);
        r.flush     = 1'(f);
        r.bubble    = 1'(b);
        r.valid     = 1'(v);
        r.ctrl      = 4'(c);
        r.data      = 32'(d);
        r.exp_valid = 1'(ev);
        r.exp_ctrl  = 4'(ec);
        r.exp_data  = 32'(ed);
        r.exp_svld  = 3'(es);
        r.exp_cnt   = 16'(en);
        return r;
    endfunction

    // Count one comparison and report it if observed differs from expected.
    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus3(input vec_t v);
        bus3.stall_i  = v.stall;
        bus3.flush_i  = v.flush;
        bus3.bubble_i = v.bubble;
        bus3.valid_i  = v.valid;
        bus3.ctrl_i   = v.ctrl;
        bus3.data_i   = v.data;
    endtask

    task automatic applyStimulus2(input vec_t v);
        bus2.stall_i  = v.stall;
        bus2.flush_i  = v.flush;
        bus2.bubble_i = v.bubble;
        bus2.valid_i  = v.valid;
        bus2.ctrl_i   = v.ctrl;
        bus2.data_i   = v.data;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t idle;
        vec_t busy;
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // stall, flush, bubble, valid, ctrl, data | exp valid, ctrl, data, svld, cnt
        tab3[0]  = mk(0, 0, 0, 1, 'h9, 1,   0, 0,   0, 'b001, 0);
        tab3[1]  = mk(0, 0, 0, 1, 'hA, 2,   0, 0,   0, 'b011, 0);
        tab3[2]  = mk(0, 0, 0, 1, 'hB, 3,   1, 'h9, 1, 'b111, 0);
        tab3[3]  = mk(0, 0, 0, 1, 'hC, 4,   1, 'hA, 2, 'b111, 0);
        tab3[4]  = mk(1, 0, 1, 1, 'hD, 5,   1, 'hA, 2, 'b111, 0);
        tab3[5]  = mk(1, 0, 1, 1, 'hD, 5,   1, 'hA, 2, 'b111, 0);
        tab3[6]  = mk(0, 0, 0, 1, 'hD, 5,   1, 'hB, 3, 'b111, 0);
        tab3[7]  = mk(0, 0, 0, 0, 'hF, 'h77, 1, 'hC, 4, 'b110, 0);
        tab3[8]  = mk(0, 0, 0, 0, 'hF, 'h77, 1, 'hD, 5, 'b100, 0);
        tab3[9]  = mk(0, 0, 0, 1, 'hE, 6,   0, 0,   0, 'b001, 0);
        tab3[10] = mk(0, 0, 0, 1, 'h1, 7,   0, 0,   0, 'b011, 0);
        tab3[11] = mk(0, 0, 0, 1, 'h2, 8,   1, 'hE, 6, 'b111, 0);
        tab3[12] = mk(1, 1, 0, 1, 'h4, 9,   0, 0,   0, 'b000, 0);
        tab3[13] = mk(0, 0, 0, 1, 'h3, 9,   0, 0,   0, 'b001, 0);
        tab3[14] = mk(0, 0, 0, 0, 'hF, 0,   0, 0,   0, 'b010, 0);
        tab3[15] = mk(0, 0, 0, 0, 'hF, 0,   1, 'h3, 9, 'b100, 0);
        tab3[16] = mk(0, 0, 0, 0, 0,   0,   0, 0,   0, 'b000, 0);

        tab2[0]  = mk(0, 0, 0, 1, 'h5, 'hA0, 0, 0,   0,     'b01, 0);
        tab2[1]  = mk(0, 0, 1, 1, 'h7, 'hEE, 1, 'h5, 'hA0, 'b10, 1);
        tab2[2]  = mk(0, 0, 0, 1, 'h6, 'hB0, 0, 0,   0,     'b01, 1);
        tab2[3]  = mk(0, 0, 0, 0, 'hF, 'h33, 1, 'h6, 'hB0, 'b10, 1);
        tab2[4]  = mk(0, 0, 0, 0, 'hF, 'h33, 0, 0,   0,     'b00, 1);
        tab2[5]  = mk(0, 1, 1, 1, 'h7, 'h44, 0, 0,   0,     'b00, 1);

        // Reset held with a live, all-ones-control bundle at the inputs.
        busy = mk(0, 0, 0, 1, 0, 'hAA, 0, 0, 0, 0, 0);
        busy.ctrl = ctrl_pack(1'b1, 2'b11, 1'b1);
        rst = 1'b1;
        applyStimulus3(busy);
        applyStimulus2(busy);
        for (int i = 0; i < 2; i++) begin
            tick();
            checkOutput($sformatf("rst%0d valid3", i), 64'(bus3.valid_o), 64'(0));
            checkOutput($sformatf("rst%0d ctrl3", i), 64'(bus3.ctrl_o), 64'(0));
            checkOutput($sformatf("rst%0d data3", i), 64'(bus3.data_o), 64'(0));
            checkOutput($sformatf("rst%0d cnt3", i), 64'(bus3.bubble_cnt_o), 64'(0));
            checkOutput($sformatf("rst%0d svld3", i), 64'(bus3.stage_vld_o), 64'(0));
            checkOutput($sformatf("rst%0d valid2", i), 64'(bus2.valid_o), 64'(0));
            checkOutput($sformatf("rst%0d cnt2", i), 64'(bus2.bubble_cnt_o), 64'(0));
        end
        rst = 1'b0;
        tick();
        checkOutput("post_rst valid3", 64'(bus3.valid_o), 64'(0));
        checkOutput("post_rst ctrl3", 64'(bus3.ctrl_o), 64'(0));
        checkOutput("post_rst data3", 64'(bus3.data_o), 64'(0));
        checkOutput("post_rst cnt3", 64'(bus3.bubble_cnt_o), 64'(0));
        checkOutput("post_rst svld3", 64'(bus3.stage_vld_o), 64'(3'b001));
        checkOutput("post_rst valid2", 64'(bus2.valid_o), 64'(0));

        // Clear the pipes again before the directed sequences.
        applyStimulus3(idle);
        applyStimulus2(idle);
        rst = 1'b1;
        tick();
        rst = 1'b0;

        $display("[TB] 3-stage stream, stall and flush");
        for (int i = 0; i < 17; i++) begin
            applyStimulus3(tab3[i]);
            tick();
            checkOutput($sformatf("s3[%0d] valid", i), 64'(bus3.valid_o), 64'(tab3[i].exp_valid));
            checkOutput($sformatf("s3[%0d] ctrl", i), 64'(bus3.ctrl_o), 64'(tab3[i].exp_ctrl));
            checkOutput($sformatf("s3[%0d] svld", i), 64'(bus3.stage_vld_o), 64'(tab3[i].exp_svld));
            checkOutput($sformatf("s3[%0d] cnt", i), 64'(bus3.bubble_cnt_o), 64'(tab3[i].exp_cnt));
            if (tab3[i].exp_valid)
                checkOutput($sformatf("s3[%0d] data", i), 64'(bus3.data_o), 64'(tab3[i].exp_data));
        end
        applyStimulus3(idle);

        $display("[TB] 2-stage bubbles");
        for (int i = 0; i < 6; i++) begin
            applyStimulus2(tab2[i]);
            tick();
            checkOutput($sformatf("s2[%0d] valid", i), 64'(bus2.valid_o), 64'(tab2[i].exp_valid));
            checkOutput($sformatf("s2[%0d] ctrl", i), 64'(bus2.ctrl_o), 64'(tab2[i].exp_ctrl));
            checkOutput($sformatf("s2[%0d] svld", i), 64'(bus2.stage_vld_o), 64'(tab2[i].exp_svld[1:0]));
            checkOutput($sformatf("s2[%0d] cnt", i), 64'(bus2.bubble_cnt_o), 64'(tab2[i].exp_cnt[3:0]));
            if (tab2[i].exp_valid)
                checkOutput($sformatf("s2[%0d] data", i), 64'(bus2.data_o), 64'(tab2[i].exp_data));
        end

        // One bubble already counted; 16 more must saturate a 4-bit count.
        $display("[TB] bubble counter saturation");
        busy = idle;
        busy.bubble = 1'b1;
        applyStimulus2(busy);
        for (int i = 0; i < 16; i++) begin
            int exp_cnt;
            tick();
            exp_cnt = (i + 2 > 15) ? 15 : i + 2;
            checkOutput($sformatf("sat[%0d] cnt", i), 64'(bus2.bubble_cnt_o), 64'(exp_cnt));
            checkOutput($sformatf("sat[%0d] valid", i), 64'(bus2.valid_o), 64'(0));
        end

        applyStimulus2(idle);
        rst = 1'b1;
        tick();
        checkOutput("final_rst cnt2", 64'(bus2.bubble_cnt_o), 64'(0));
        checkOutput("final_rst svld2", 64'(bus2.stage_vld_o), 64'(0));
        rst = 1'b0;
        tick();
        checkOutput("after_rst cnt2", 64'(bus2.bubble_cnt_o), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
